// File: rtl/key_pkg.sv
// key_pkg: definitions shared by the key input blocks.
//   key_fsm_e          per-key debounce/classification state
//   DefNumKeys         default number of key channels on the board
//   DefDebounceCycles  20 ms at 50 MHz
//   DefLongPressCycles 1 s at 50 MHz
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_fsm_e;

    localparam int unsigned DefNumKeys         = 4;
    localparam int unsigned DefDebounceCycles  = 1_000_000;
    localparam int unsigned DefLongPressCycles = 50_000_000;

endpackage

// File: rtl/key_filter.sv
// key_filter: one key channel. Synchronises an active-low raw button, debounces it and
// classifies it into press / release / long-press events.
//   clk          system clock
//   rst_n        synchronous active-low reset
//   key_n        raw button pin, active-low, asynchronous
//   key_state    debounced level, 1 while pressed
//   key_press    one-cycle pulse on an accepted press
//   key_release  one-cycle pulse on an accepted release
//   key_long     one-cycle pulse when a hold reaches LONG_PRESS_CYCLES
module key_filter
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DefDebounceCycles,
    parameter int unsigned LONG_PRESS_CYCLES = DefLongPressCycles
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned CntW = $clog2(LONG_PRESS_CYCLES + 1);
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t DebLast  = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t LongLast = cnt_t'(LONG_PRESS_CYCLES - 1);
    localparam cnt_t LongMax  = cnt_t'(LONG_PRESS_CYCLES);
    localparam cnt_t CntOne   = cnt_t'(1);

    // sync_q holds the raw (active-low) pin; bit 1 is the second stage.
    logic [1:0] sync_q;
    logic       pressed;

    key_fsm_e state_q, state_d;
    cnt_t     cnt_q, cnt_d;
    cnt_t     dcnt_q, dcnt_d;
    logic     level_q, level_d;
    logic     press_q, press_d;
    logic     release_q, release_d;
    logic     long_q, long_d;

    assign pressed = ~sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            PRESSED: begin
                if (cnt_q == LongLast) begin
                    long_d = 1'b1;
                end
                // Saturating at LongMax is what makes key_long fire only once per press.
                if (cnt_q != LongMax) begin
                    cnt_d = cnt_q + CntOne;
                end
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                // Hold time keeps running so a rejected release bounce leaves key_long timing intact.
                if (cnt_q != LongMax) begin
                    cnt_d = cnt_q + CntOne;
                end
                if (pressed) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DebLast) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                    dcnt_d    = '0;
                end else begin
                    dcnt_d = dcnt_q + CntOne;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_state   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_scan.sv
// key_scan: NUM_KEYS independent debounced key channels.
//   clk          system clock (50 MHz)
//   rst_n        synchronous active-low reset
//   key_n        raw button pins, active-low, asynchronous
//   key_state    debounced levels, 1 while pressed
//   key_press    one-cycle press pulses
//   key_release  one-cycle release pulses
//   key_long     one-cycle long-press pulses
module key_scan
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS          = DefNumKeys,
    parameter int unsigned DEBOUNCE_CYCLES   = DefDebounceCycles,
    parameter int unsigned LONG_PRESS_CYCLES = DefLongPressCycles
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_filter #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_key_filter (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_n      (key_n[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: directed stimulus for key_scan with a cycle-level behavioural model
// checked every cycle, plus literal latency / count expectations.
module tb_key_scan;

    localparam int unsigned N    = 4;
    localparam int unsigned DEB  = 8;
    localparam int unsigned LONG = 64;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] key_n;
    logic [N-1:0] key_state;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;

    key_scan #(
        .NUM_KEYS         (N),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: raw pin pipeline, debounced level, length of the current run of samples that
    // disagree with the debounced level, and cycles elapsed since the accepted press.
    logic [N-1:0] m_s1, m_s2, m_deb;
    int           m_run[N];
    int           m_age[N];
    logic [N-1:0] e_press, e_rel, e_long;

    // Event log taken from DUT outputs, for the literal expectations.
    int press_t[N], rel_t[N], long_t[N];
    int press_n[N], rel_n[N], long_n[N];

    task automatic model_advance();
        logic s;
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_deb = '0;
            e_press = '0; e_rel = '0; e_long = '0;
            for (int k = 0; k < N; k++) begin
                m_run[k] = 0;
                m_age[k] = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                s = ~m_s2[k];
                e_press[k] = 1'b0;
                e_rel[k]   = 1'b0;
                e_long[k]  = 1'b0;
                if (!m_deb[k]) begin
                    // A level change is accepted after DEB+1 consecutive disagreeing samples.
                    if (s) begin
                        m_run[k]++;
                        if (m_run[k] == DEB + 1) begin
                            m_deb[k] = 1'b1; e_press[k] = 1'b1;
                            m_run[k] = 0; m_age[k] = 0;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end else begin
                    if (m_run[k] == 0 && m_age[k] + 1 == LONG) e_long[k] = 1'b1;
                    if (m_age[k] < LONG) m_age[k]++;
                    if (!s) begin
                        m_run[k]++;
                        if (m_run[k] == DEB + 1) begin
                            m_deb[k] = 1'b0; e_rel[k] = 1'b1; m_run[k] = 0;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = key_n[k];
            end
        end
    endtask

    // One clock: advance the model over the posedge just taken, compare, log events.
    task automatic step();
        @(negedge clk);
        cyc++;
        model_advance();
        checks++;
        if ({key_state, key_press, key_release, key_long} !== {m_deb, e_press, e_rel, e_long}) begin
            errors++;
            $display("FAIL model cyc=%0d state/press/rel/long got %b %b %b %b want %b %b %b %b",
                     cyc, key_state, key_press, key_release, key_long,
                     m_deb, e_press, e_rel, e_long);
        end
        for (int k = 0; k < N; k++) begin
            if (key_press[k] === 1'b1)   begin press_t[k] = cyc; press_n[k]++; end
            if (key_release[k] === 1'b1) begin rel_t[k]   = cyc; rel_n[k]++;   end
            if (key_long[k] === 1'b1)    begin long_t[k]  = cyc; long_n[k]++;  end
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    int t, tr, snap_p, snap_r, snap_l;

    initial begin
        for (int k = 0; k < N; k++) begin
            press_t[k] = -1; rel_t[k] = -1; long_t[k] = -1;
            press_n[k] = 0;  rel_n[k] = 0;  long_n[k] = 0;
            m_run[k] = 0;    m_age[k] = 0;
        end
        m_s1 = '1; m_s2 = '1; m_deb = '0;
        e_press = '0; e_rel = '0; e_long = '0;

        // Reset with all keys held: outputs stay 0, then all four press together.
        key_n = 4'b0000;
        rst_n = 1'b0;
        wait_cycles(200);
        check("rst_quiet_press_count", press_n[0] + press_n[1] + press_n[2] + press_n[3], 0);
        rst_n = 1'b1;
        t = cyc;
        wait_cycles(15);
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_press_time[%0d]", k), press_t[k], t + 11);
            check($sformatf("rst_press_count[%0d]", k), press_n[k], 1);
        end
        check("rst_state_all", int'(key_state), 15);
        key_n = 4'b1111;
        t = cyc;
        wait_cycles(15);
        for (int k = 0; k < N; k++) check($sformatf("rel_time[%0d]", k), rel_t[k], t + 11);
        wait_cycles(5);

        // Clean press on key 0, held for the rest of the run.
        key_n[0] = 1'b0;
        t = cyc;
        wait_cycles(15);
        check("clean_press_time", press_t[0], t + 11);
        check("clean_state", int'(key_state), 1);

        // Bounce rejection on key 1.
        snap_p = press_n[1]; snap_r = rel_n[1]; snap_l = long_n[1];
        for (int r = 0; r < 4; r++) begin
            key_n[1] = 1'b0; wait_cycles(5);
            key_n[1] = 1'b1; wait_cycles(3);
        end
        wait_cycles(15);
        check("bounce_press", press_n[1] - snap_p, 0);
        check("bounce_release", rel_n[1] - snap_r, 0);
        check("bounce_long", long_n[1] - snap_l, 0);
        check("bounce_state", int'(key_state[1]), 0);

        // Long press on key 2, then release.
        snap_l = long_n[2];
        key_n[2] = 1'b0;
        t = cyc;
        wait_cycles(200);
        check("long_press_time", press_t[2], t + 11);
        check("long_time", long_t[2], t + 11 + 64);
        check("long_count", long_n[2] - snap_l, 1);
        key_n[2] = 1'b1;
        tr = cyc;
        wait_cycles(15);
        check("long_release_time", rel_t[2], tr + 11);

        // Release bounce on key 3 while pressed.
        snap_r = rel_n[3];
        key_n[3] = 1'b0;
        t = cyc;
        wait_cycles(20);
        key_n[3] = 1'b1; wait_cycles(4);
        key_n[3] = 1'b0; wait_cycles(60);
        check("rbounce_release", rel_n[3] - snap_r, 0);
        check("rbounce_state", int'(key_state[3]), 1);
        check("rbounce_long_time", long_t[3], t + 11 + 64);
        key_n[3] = 1'b1;
        wait_cycles(15);

        // One-cycle reset while key 0 is pressed and held.
        snap_r = rel_n[0];
        rst_n = 1'b0;
        wait_cycles(1);
        check("midrst_state", int'(key_state[0]), 0);
        rst_n = 1'b1;
        tr = cyc;
        wait_cycles(15);
        check("midrst_press_time", press_t[0], tr + 11);
        check("midrst_no_release", rel_n[0] - snap_r, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
